fp_mul_arbiter: RTL and testbench

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one floating-point multiplier among NUM_REQ
// requesters. It issues one operation at a time, waits for done with a
// timeout, and returns the result on a valid/ready response channel.
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [32*NUM_REQ-1:0]        req_a_i,
  input  logic [32*NUM_REQ-1:0]        req_b_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
  output logic [31:0]                  rsp_product_o,
  output logic [4:0]                   rsp_flags_o,
  output logic                         mul_start_o,
  output logic [31:0]                  mul_a_o,
  output logic [31:0]                  mul_b_o,
  input  logic                         mul_done_i,
  input  logic                         mul_nan_i,
  input  logic                         mul_infinit_i,
  input  logic                         mul_overflow_i,
  input  logic                         mul_underflow_i,
  input  logic [31:0]                  mul_product_i,
  output logic                         busy_o
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [7:0]       timer_q, timer_d;
  logic             start_q, start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      product_q, product_d;
  logic [4:0]       flags_q, flags_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [IDW-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [31:0]      a_sel, b_sel;

  // Round-robin search from last_grant+1 with wrap; constant indices only.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!found && req_valid_i[k] && (k == (32'(last_grant_q) + i) % NUM_REQ)) begin
          found     = 1'b1;
          grant_idx = IDW'(k);
        end
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      grant_oh[k] = found && (grant_idx == IDW'(k));
      if (grant_oh[k]) begin
        a_sel = req_a_i[32*k +: 32];
        b_sel = req_b_i[32*k +: 32];
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/RESP FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    timer_d      = timer_q;
    start_d      = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    product_d    = product_q;
    flags_d      = flags_q;
    req_ready_o  = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = grant_oh;
        // found implies the granted bit is valid, so this is the acceptance.
        if (found) begin
          a_d          = a_sel;
          b_d          = b_sel;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          start_d      = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done_i) begin
          product_d   = mul_product_i;
          flags_d     = {1'b0, mul_underflow_i, mul_overflow_i, mul_infinit_i, mul_nan_i};
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          product_d   = 32'h7FC0_0000;
          flags_d     = 5'b10000;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      timer_q      <= '0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      product_q    <= '0;
      flags_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      timer_q      <= timer_d;
      start_q      <= start_d;
      rsp_valid_q  <= rsp_valid_d;
      product_q    <= product_d;
      flags_q      <= flags_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = id_q;
  assign rsp_product_o = product_q;
  assign rsp_flags_o   = flags_q;
  assign mul_start_o   = start_q;
  assign mul_a_o       = a_q;
  assign mul_b_o       = b_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural multiplier stand-in.
module tb_fp_mul_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid_i = '0;
  logic [NR-1:0]     req_ready_o;
  logic [32*NR-1:0]  req_a_i = '0;
  logic [32*NR-1:0]  req_b_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic [1:0]        rsp_id_o;
  logic [31:0]       rsp_product_o;
  logic [4:0]        rsp_flags_o;
  logic              mul_start_o;
  logic [31:0]       mul_a_o, mul_b_o;
  logic              mul_done_i;
  logic              mul_nan_i, mul_infinit_i, mul_overflow_i, mul_underflow_i;
  logic [31:0]       mul_product_i;
  logic              busy_o;

  fp_mul_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_product_o(rsp_product_o), .rsp_flags_o(rsp_flags_o),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_done_i(mul_done_i), .mul_nan_i(mul_nan_i), .mul_infinit_i(mul_infinit_i),
    .mul_overflow_i(mul_overflow_i), .mul_underflow_i(mul_underflow_i),
    .mul_product_i(mul_product_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: raises done m_delay cycles after start (0 = never).
  logic [31:0] m_prod = '0;
  logic [3:0]  m_flags = '0;   // {underflow, overflow, infinit, nan}
  logic [7:0]  m_delay = 8'd3;
  logic        m_pend = 1'b0;
  logic [7:0]  m_cnt = '0;
  logic        force_done = 1'b0;
  logic        model_done;

  assign model_done      = m_pend && (m_delay != 0) && (m_cnt == m_delay);
  assign mul_done_i      = model_done | force_done;
  assign mul_product_i   = m_prod;
  assign {mul_underflow_i, mul_overflow_i, mul_infinit_i, mul_nan_i} = m_flags;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_cnt  <= '0;
    end else if (mul_start_o) begin
      m_pend <= 1'b1;
      m_cnt  <= 8'd1;
    end else if (model_done) begin
      m_pend <= 1'b0;
    end else if (m_pend) begin
      m_cnt <= m_cnt + 8'd1;
    end
  end

  // Counts cycles where more than one ready bit is high.
  int oh_viol = 0;
  always @(negedge clk) if (rst_n && !$onehot0(req_ready_o)) oh_viol++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] a, b;
    logic [31:0] m_prod;
    logic [3:0]  m_flags;
    int          delay;
    logic [31:0] exp_prod;
    logic [4:0]  exp_flags;
  } vec_t;

  // One complete transaction for a single requester, with full checking.
  task automatic run_txn(input vec_t v, input bit late_done);
    int cnt;
    int extra_start;
    int exp_lat;
    m_prod  = v.m_prod;
    m_flags = v.m_flags;
    m_delay = 8'(v.delay);
    req_a_i = {NR{32'hDEAD_0001}};
    req_b_i = {NR{32'hBEEF_0002}};
    req_a_i[32*v.id +: 32] = v.a;
    req_b_i[32*v.id +: 32] = v.b;
    req_valid_i = NR'(1) << v.id;
    #1;
    cnt = 0;
    while (req_ready_o == '0 && cnt < 20) begin
      @(posedge clk); #2; cnt++;
    end
    check("grant", 64'(req_ready_o), 64'(NR'(1) << v.id));
    @(posedge clk); #1;
    req_valid_i = '0;
    check("start_pulse", 64'(mul_start_o), 64'd1);
    check("mul_a", 64'(mul_a_o), 64'(v.a));
    check("mul_b", 64'(mul_b_o), 64'(v.b));
    extra_start = 0;
    cnt = 0;
    while (!rsp_valid_o && cnt < 300) begin
      @(posedge clk); #1; cnt++;
      if (mul_start_o) extra_start++;
    end
    exp_lat = (v.delay == 0) ? TO + 1 : v.delay + 1;
    check("rsp_latency", 64'(cnt), 64'(exp_lat));
    check("single_start", 64'(extra_start), 64'd0);
    check("rsp_id", 64'(rsp_id_o), 64'(v.id));
    check("rsp_product", 64'(rsp_product_o), 64'(v.exp_prod));
    check("rsp_flags", 64'(rsp_flags_o), 64'(v.exp_flags));
    if (late_done) begin
      m_prod = 32'h1234_5678;
      m_flags = 4'b1111;
      force_done = 1'b1;
      @(posedge clk); #1;
      force_done = 1'b0;
      check("late_done_ignored", {31'd0, rsp_valid_o, rsp_product_o},
            {31'd0, 1'b1, v.exp_prod});
      check("late_done_flags", 64'(rsp_flags_o), 64'(v.exp_flags));
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    check("rsp_done_idle", 64'({rsp_valid_o, busy_o}), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int cnt;
    vecs[0] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 3, 32'h40C0_0000, 5'b00000};
    vecs[1] = '{2, 32'h7FC0_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0001, 3, 32'h0000_0000, 5'b00001};
    vecs[2] = '{1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0110, 2, 32'h7F80_0000, 5'b00110};
    vecs[3] = '{1, 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0010, 1, 32'h7F80_0000, 5'b00010};
    vecs[4] = '{0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 6, 32'h3F80_0000, 5'b00000};
    vecs[5] = '{3, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b1000, 4, 32'h0000_0000, 5'b01000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {rsp_valid_o, mul_start_o, busy_o, rsp_id_o, rsp_flags_o},
          64'd0);
    check("rst_product", 64'(rsp_product_o), 64'd0);
    check("rst_mul_ops", {mul_a_o, mul_b_o}, 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0);

    // All requesters valid: grants rotate 0,1,2,3,0,...
    m_prod = 32'h4080_0000; m_flags = '0; m_delay = 8'd3;
    for (int k = 0; k < NR; k++) begin
      req_a_i[32*k +: 32] = 32'h3F80_0000 + 32'(k);
      req_b_i[32*k +: 32] = 32'h4000_0000 + 32'(k);
    end
    req_valid_i = '1;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cnt = 0;
      while (!rsp_valid_o && cnt < 50) begin
        @(posedge clk); #1; cnt++;
      end
      check("rr_id", 64'(rsp_id_o), 64'(i % NR));
      @(posedge clk); #1;
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    check("rr_onehot", 64'(oh_viol), 64'd0);

    // Timeout with a late done while the response is pending
    run_txn('{2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 0,
              32'h7FC0_0000, 5'b10000}, 1'b1);

    // Response back-pressure: outputs stable, no acceptance during RESP
    m_prod = 32'h3F80_0000; m_flags = '0; m_delay = 8'd2;
    req_a_i = {NR{32'h3F80_0000}};
    req_b_i = {NR{32'h3F80_0000}};
    req_valid_i = 4'b0010;
    #1;
    cnt = 0;
    while (req_ready_o == '0 && cnt < 20) begin
      @(posedge clk); #2; cnt++;
    end
    check("stall_grant", 64'(req_ready_o), 64'h2);
    @(posedge clk); #1;
    req_valid_i = '1;
    cnt = 0;
    while (!rsp_valid_o && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", {req_ready_o, rsp_valid_o, rsp_id_o, rsp_flags_o, rsp_product_o},
            {4'b0000, 1'b1, 2'd1, 5'b00000, 32'h3F80_0000});
      @(posedge clk); #1;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    check("stall_release", 64'({busy_o, rsp_valid_o, req_ready_o}), 64'({2'b00, 4'b0100}));
    req_valid_i = '0;

    // Reset during WAIT discards the transaction
    m_delay = 8'd0;
    req_valid_i = 4'b1000;
    #1;
    cnt = 0;
    while (req_ready_o == '0 && cnt < 20) begin
      @(posedge clk); #2; cnt++;
    end
    @(posedge clk); #1;
    req_valid_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("wait_busy", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_state", 64'({busy_o, rsp_valid_o, mul_start_o}), 64'd0);
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    @(posedge clk); #1;
    check("midrst_done_ignored", 64'({busy_o, rsp_valid_o}), 64'd0);
    req_valid_i = '1;
    #1;
    check("midrst_first_grant", 64'(req_ready_o), 64'h1);
    req_valid_i = '0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
